control_unit: RTL and testbench

//  Multicycle FSM that drives every datapath control line of cpu from OPCODE/FUNCT and ALU/Mult/Div status.
//  It is the producer side of the control interface that cpu consumes. It sequences fetch, decode, execute, memory, writeback and exceptions.

---
 rtl/cpu_ctrl_pkg.sv | 90 +++++++++
 rtl/control_unit_decoder.sv | 45 ++++
 rtl/control_unit.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the multicycle CPU: states, opcodes/functs,
// instruction classes and every mux-select / ALU / shifter code.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_LB   = 6'h20;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1a;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_RTE  = 6'h13;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_CMP  = 3'b111;

  localparam logic [2:0] SH_HOLD = 3'b000;
  localparam logic [2:0] SH_LOAD = 3'b001;
  localparam logic [2:0] SH_SLL  = 3'b010;
  localparam logic [2:0] SH_SRL  = 3'b011;
  localparam logic [2:0] SH_SRA  = 3'b100;

  localparam logic [3:0] SRCB_B    = 4'd0;
  localparam logic [3:0] SRCB_4    = 4'd1;
  localparam logic [3:0] SRCB_SE   = 4'd2;
  localparam logic [3:0] SRCB_SE2  = 4'd3;

  // MTR_SHIFT routes the shifter result into the register file.
  localparam logic [3:0] MTR_WSRC  = 4'd0;
  localparam logic [3:0] MTR_MDR   = 4'd1;
  localparam logic [3:0] MTR_BYTE  = 4'd2;
  localparam logic [3:0] MTR_LUI   = 4'd3;
  localparam logic [3:0] MTR_SHIFT = 4'd4;

  localparam logic [3:0] RD_RT = 4'd0;
  localparam logic [3:0] RD_RD = 4'd1;
  localparam logic [3:0] RD_RA = 4'd2;

  localparam logic [3:0] PCS_ALU    = 4'd0;
  localparam logic [3:0] PCS_ALUOUT = 4'd1;
  localparam logic [3:0] PCS_JUMP   = 4'd2;
  localparam logic [3:0] PCS_EPC    = 4'd3;
  localparam logic [3:0] PCS_BYTE   = 4'd4;

  localparam logic [3:0] WS_ALUOUT = 4'd0;
  localparam logic [3:0] WS_HI     = 4'd1;
  localparam logic [3:0] WS_LO     = 4'd2;
  localparam logic [3:0] WS_PC     = 4'd3;

  localparam logic [3:0] EXC_NONE   = 4'd0;
  localparam logic [3:0] EXC_OPCODE = 4'd1;
  localparam logic [3:0] EXC_OVF    = 4'd2;
  localparam logic [3:0] EXC_DIV0   = 4'd3;

  typedef enum logic [5:0] {
    S_FETCH0 = 6'd0, S_FETCH_W, S_FETCH1, S_DECODE,
    S_EXEC_R, S_WB_R, S_SH_LOAD, S_SH_OP, S_WB_SH,
    S_EXEC_I, S_WB_I, S_WB_LUI,
    S_ADDR, S_MEM_RD, S_MEM_W, S_MEM_MDR, S_WB_LD, S_MEM_WR,
    S_BR, S_JMP, S_JAL_WB, S_JR, S_RTE,
    S_MULDIV, S_MD_ZERO, S_MF_WB,
    S_EXC0, S_EXC1, S_EXC_W, S_EXC_MDR, S_EXC_PC
  } state_e;

  typedef enum logic [4:0] {
    CLS_NOP, CLS_ADD, CLS_SUB, CLS_AND, CLS_SLL, CLS_SRL, CLS_SRA,
    CLS_JR, CLS_MULT, CLS_DIV, CLS_MFHI, CLS_MFLO, CLS_RTE,
    CLS_ADDI, CLS_BEQ, CLS_BNE, CLS_LW, CLS_SW, CLS_LB, CLS_LUI,
    CLS_J, CLS_JAL
  } instr_class_e;

endpackage

// File: rtl/control_unit_decoder.sv
// Combinational OPCODE/FUNCT classifier; anything outside the subset raises illegal.
module ctrl_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  output logic [4:0] instrClass,
  output logic       illegal
);

  always_comb begin
    instrClass = CLS_NOP;
    illegal    = 1'b0;
    case (OPCODE)
      OP_R: begin
        case (FUNCT)
          FN_ADD:  instrClass = CLS_ADD;
          FN_SUB:  instrClass = CLS_SUB;
          FN_AND:  instrClass = CLS_AND;
          FN_SLL:  instrClass = CLS_SLL;
          FN_SRL:  instrClass = CLS_SRL;
          FN_SRA:  instrClass = CLS_SRA;
          FN_JR:   instrClass = CLS_JR;
          FN_MULT: instrClass = CLS_MULT;
          FN_DIV:  instrClass = CLS_DIV;
          FN_MFHI: instrClass = CLS_MFHI;
          FN_MFLO: instrClass = CLS_MFLO;
          FN_RTE:  instrClass = CLS_RTE;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: instrClass = CLS_ADDI;
      OP_BEQ:  instrClass = CLS_BEQ;
      OP_BNE:  instrClass = CLS_BNE;
      OP_LW:   instrClass = CLS_LW;
      OP_SW:   instrClass = CLS_SW;
      OP_LB:   instrClass = CLS_LB;
      OP_LUI:  instrClass = CLS_LUI;
      OP_J:    instrClass = CLS_J;
      OP_JAL:  instrClass = CLS_JAL;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM for the cpu datapath. Define CTRL_EXCEPTIONS_EN to run
// the overflow / illegal-opcode / div0 exception sequence; otherwise those are ignored.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT       = 1,
  parameter int unsigned MULDIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       ALUoverflow,
  input  logic       Zero,
  input  logic       ByZero,
  output logic       PCwrite,
  output logic       MemWrite,
  output logic       MemRead,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       EPCWrite,
  output logic       HIWrite,
  output logic       LOWrite,
  output logic       IorD,
  output logic       AluSrcA,
  output logic       DivMult,
  output logic [3:0] AluSrcB,
  output logic [3:0] MemToReg,
  output logic [3:0] RegDest,
  output logic [3:0] PCSource,
  output logic [3:0] WriteSrc,
  output logic [3:0] Exception,
  output logic [2:0] ALUControl,
  output logic [2:0] ShiftControl,
  output logic [5:0] ctrl_state
);

`ifdef CTRL_EXCEPTIONS_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  localparam int unsigned CNT_MAX = (MULDIV_CYCLES > MEM_LAT) ? MULDIV_CYCLES : MEM_LAT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  state_e             state, nextState;
  instr_class_e       clsQ, decCls;
  logic [4:0]         decClass;
  logic               decIllegal;
  logic [3:0]         excCode, excNext;
  logic [CNT_W-1:0]   cnt;

  ctrl_decoder uDecoder (
    .OPCODE     (OPCODE),
    .FUNCT      (FUNCT),
    .instrClass (decClass),
    .illegal    (decIllegal)
  );

  assign decCls     = instr_class_e'(decClass);
  assign ctrl_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH0;
    else       state <= nextState;
  end

  // Latched instruction class, exception code and the shared wait/MULDIV counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clsQ    <= CLS_NOP;
      excCode <= EXC_NONE;
      cnt     <= '0;
    end else begin
      if (state == S_DECODE) clsQ <= decCls;
      excCode <= excNext;
      if (nextState != state) begin
        if (nextState == S_MULDIV) cnt <= CNT_W'(MULDIV_CYCLES - 1);
        else                       cnt <= CNT_W'(MEM_LAT - 1);
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    nextState    = state;
    excNext      = excCode;
    PCwrite      = 1'b0;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    EPCWrite     = 1'b0;
    HIWrite      = 1'b0;
    LOWrite      = 1'b0;
    IorD         = 1'b0;
    AluSrcA      = 1'b0;
    DivMult      = 1'b0;
    AluSrcB      = SRCB_B;
    MemToReg     = MTR_WSRC;
    RegDest      = RD_RT;
    PCSource     = PCS_ALU;
    WriteSrc     = WS_ALUOUT;
    Exception    = EXC_NONE;
    ALUControl   = ALU_PASS;
    ShiftControl = SH_HOLD;
    // Reset forces every output low immediately, even though state is already FETCH0.
    if (!reset) begin
      case (state)
        S_FETCH0: begin
          MemRead = 1'b1; AluSrcB = SRCB_4; ALUControl = ALU_ADD;
          nextState = S_FETCH_W;
        end
        S_FETCH_W: begin
          MemRead = 1'b1; AluSrcB = SRCB_4; ALUControl = ALU_ADD;
          if (cnt == '0) nextState = S_FETCH1;
        end
        S_FETCH1: begin
          IRWrite = 1'b1; PCwrite = 1'b1; PCSource = PCS_ALU;
          AluSrcB = SRCB_4; ALUControl = ALU_ADD;
          nextState = S_DECODE;
        end
        S_DECODE: begin
          AluSrcB = SRCB_SE2; ALUControl = ALU_ADD;
          if (decIllegal) begin
            nextState = EXC_EN ? S_EXC0 : S_FETCH0;
            excNext   = EXC_OPCODE;
          end else begin
            case (decCls)
              CLS_ADD, CLS_SUB, CLS_AND: nextState = S_EXEC_R;
              CLS_SLL, CLS_SRL, CLS_SRA: nextState = S_SH_LOAD;
              CLS_JR:                    nextState = S_JR;
              CLS_RTE:                   nextState = S_RTE;
              CLS_MULT:                  nextState = S_MULDIV;
              CLS_DIV: begin
                if (ByZero) begin
                  nextState = EXC_EN ? S_EXC0 : S_MD_ZERO;
                  excNext   = EXC_DIV0;
                end else begin
                  nextState = S_MULDIV;
                end
              end
              CLS_MFHI, CLS_MFLO:        nextState = S_MF_WB;
              CLS_ADDI:                  nextState = S_EXEC_I;
              CLS_BEQ, CLS_BNE:          nextState = S_BR;
              CLS_LW, CLS_LB, CLS_SW:    nextState = S_ADDR;
              CLS_LUI:                   nextState = S_WB_LUI;
              CLS_J:                     nextState = S_JMP;
              CLS_JAL:                   nextState = S_JAL_WB;
              default:                   nextState = S_FETCH0;
            endcase
          end
        end
        S_EXEC_R: begin
          AluSrcA = 1'b1; AluSrcB = SRCB_B;
          ALUControl = (clsQ == CLS_SUB) ? ALU_SUB : (clsQ == CLS_AND) ? ALU_AND : ALU_ADD;
          if (EXC_EN && ALUoverflow && clsQ != CLS_AND) begin
            nextState = S_EXC0;
            excNext   = EXC_OVF;
          end else begin
            nextState = S_WB_R;
          end
        end
        S_WB_R: begin
          RegWrite = 1'b1; RegDest = RD_RD; MemToReg = MTR_WSRC; WriteSrc = WS_ALUOUT;
          nextState = S_FETCH0;
        end
        S_SH_LOAD: begin
          ShiftControl = SH_LOAD;
          nextState = S_SH_OP;
        end
        S_SH_OP: begin
          ShiftControl = (clsQ == CLS_SLL) ? SH_SLL : (clsQ == CLS_SRL) ? SH_SRL : SH_SRA;
          nextState = S_WB_SH;
        end
        S_WB_SH: begin
          RegWrite = 1'b1; RegDest = RD_RD; MemToReg = MTR_SHIFT;
          nextState = S_FETCH0;
        end
        S_EXEC_I: begin
          AluSrcA = 1'b1; AluSrcB = SRCB_SE; ALUControl = ALU_ADD;
          if (EXC_EN && ALUoverflow) begin
            nextState = S_EXC0;
            excNext   = EXC_OVF;
          end else begin
            nextState = S_WB_I;
          end
        end
        S_WB_I: begin
          RegWrite = 1'b1; RegDest = RD_RT; MemToReg = MTR_WSRC; WriteSrc = WS_ALUOUT;
          nextState = S_FETCH0;
        end
        S_WB_LUI: begin
          RegWrite = 1'b1; RegDest = RD_RT; MemToReg = MTR_LUI;
          nextState = S_FETCH0;
        end
        S_ADDR: begin
          AluSrcA = 1'b1; AluSrcB = SRCB_SE; ALUControl = ALU_ADD;
          nextState = (clsQ == CLS_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          IorD = 1'b1; MemRead = 1'b1; Exception = EXC_NONE;
          nextState = S_MEM_W;
        end
        S_MEM_W: begin
          IorD = 1'b1; MemRead = 1'b1; Exception = EXC_NONE;
          if (cnt == '0) nextState = S_MEM_MDR;
        end
        S_MEM_MDR: nextState = S_WB_LD;
        S_WB_LD: begin
          RegWrite = 1'b1; RegDest = RD_RT;
          MemToReg = (clsQ == CLS_LB) ? MTR_BYTE : MTR_MDR;
          nextState = S_FETCH0;
        end
        S_MEM_WR: begin
          IorD = 1'b1; MemWrite = 1'b1; Exception = EXC_NONE;
          nextState = S_FETCH0;
        end
        S_BR: begin
          AluSrcA = 1'b1; AluSrcB = SRCB_B; ALUControl = ALU_SUB;
          PCSource = PCS_ALUOUT;
          PCwrite  = (clsQ == CLS_BEQ) ? Zero : ~Zero;
          nextState = S_FETCH0;
        end
        S_JMP: begin
          PCwrite = 1'b1; PCSource = PCS_JUMP;
          nextState = S_FETCH0;
        end
        S_JAL_WB: begin
          RegWrite = 1'b1; RegDest = RD_RA; MemToReg = MTR_WSRC; WriteSrc = WS_PC;
          nextState = S_JMP;
        end
        S_JR: begin
          AluSrcA = 1'b1; ALUControl = ALU_PASS; PCwrite = 1'b1; PCSource = PCS_ALU;
          nextState = S_FETCH0;
        end
        S_RTE: begin
          PCwrite = 1'b1; PCSource = PCS_EPC;
          nextState = S_FETCH0;
        end
        S_MULDIV: begin
          DivMult = (clsQ == CLS_MULT);
          if (cnt == '0) begin
            HIWrite = 1'b1; LOWrite = 1'b1;
            nextState = S_FETCH0;
          end
        end
        S_MD_ZERO: begin
          HIWrite = 1'b1; LOWrite = 1'b1;
          nextState = S_FETCH0;
        end
        S_MF_WB: begin
          RegWrite = 1'b1; RegDest = RD_RD; MemToReg = MTR_WSRC;
          WriteSrc = (clsQ == CLS_MFHI) ? WS_HI : WS_LO;
          nextState = S_FETCH0;
        end
        // PC has already advanced by 4, so PC-4 is the faulting instruction.
        S_EXC0: begin
          AluSrcB = SRCB_4; ALUControl = ALU_SUB;
          nextState = S_EXC1;
        end
        S_EXC1: begin
          EPCWrite = 1'b1; IorD = 1'b1; MemRead = 1'b1; Exception = excCode;
          nextState = S_EXC_W;
        end
        S_EXC_W: begin
          IorD = 1'b1; MemRead = 1'b1; Exception = excCode;
          if (cnt == '0) nextState = S_EXC_MDR;
        end
        S_EXC_MDR: nextState = S_EXC_PC;
        S_EXC_PC: begin
          PCwrite = 1'b1; PCSource = PCS_BYTE;
          nextState = S_FETCH0;
        end
        default: nextState = S_FETCH0;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Table-driven bench for control_unit: per-instruction signal profiles plus
// hand sequences for reset behaviour and reset during a store.
module tb_control_unit;

  logic       clk, reset;
  logic [5:0] OPCODE, FUNCT;
  logic       ALUoverflow, Zero, ByZero;
  logic       PCwrite, MemWrite, MemRead, IRWrite, RegWrite, EPCWrite, HIWrite, LOWrite;
  logic       IorD, AluSrcA, DivMult;
  logic [3:0] AluSrcB, MemToReg, RegDest, PCSource, WriteSrc, Exception;
  logic [2:0] ALUControl, ShiftControl;
  logic [5:0] ctrl_state;
  logic [46:0] outBus;

  int nChecks = 0;
  int nFails  = 0;

  control_unit #(.MEM_LAT(1), .MULDIV_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT),
    .ALUoverflow(ALUoverflow), .Zero(Zero), .ByZero(ByZero),
    .PCwrite(PCwrite), .MemWrite(MemWrite), .MemRead(MemRead), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .EPCWrite(EPCWrite), .HIWrite(HIWrite), .LOWrite(LOWrite),
    .IorD(IorD), .AluSrcA(AluSrcA), .DivMult(DivMult), .AluSrcB(AluSrcB),
    .MemToReg(MemToReg), .RegDest(RegDest), .PCSource(PCSource), .WriteSrc(WriteSrc),
    .Exception(Exception), .ALUControl(ALUControl), .ShiftControl(ShiftControl),
    .ctrl_state(ctrl_state)
  );

  assign outBus = {PCwrite, MemWrite, MemRead, IRWrite, RegWrite, EPCWrite, HIWrite, LOWrite,
                   IorD, AluSrcA, DivMult, AluSrcB, MemToReg, RegDest, PCSource, WriteSrc,
                   Exception, ALUControl, ShiftControl, ctrl_state};

  always #5 clk = ~clk;

  typedef struct {
    int op, fn, zero, ovf, byz;
    int cycles, regW, memW, pcw, pcSrc, epcW, hilo, exc, mtr, wsrc, rdst;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int op, fn, zero, ovf, byz, cycles, regW, memW,
                              pcw, pcSrc, epcW, hilo, exc, mtr, wsrc, rdst);
    vec_t v;
    v.op = op; v.fn = fn; v.zero = zero; v.ovf = ovf; v.byz = byz;
    v.cycles = cycles; v.regW = regW; v.memW = memW; v.pcw = pcw; v.pcSrc = pcSrc;
    v.epcW = epcW; v.hilo = hilo; v.exc = exc; v.mtr = mtr; v.wsrc = wsrc; v.rdst = rdst;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s (vector %0d): got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  // Runs one instruction from FETCH0 until the FSM returns to FETCH0, profiling outputs.
  task automatic runVec(input vec_t v, input int idx);
    int cyc = 0, regW = 0, memW = 0, pcw = 0, pcSrc = 0, epcW = 0;
    int hi = 0, lo = 0, exc = 0, mtr = 0, wsrc = 0, rdst = 0, irw = 0, lastHi = -1;
    OPCODE = 6'(v.op); FUNCT = 6'(v.fn);
    Zero = v.zero[0]; ALUoverflow = v.ovf[0]; ByZero = v.byz[0];
    do begin
      if (RegWrite) begin regW++; mtr = int'(MemToReg); wsrc = int'(WriteSrc); rdst = int'(RegDest); end
      if (MemWrite) memW++;
      if (IRWrite) irw++;
      if (PCwrite && !IRWrite) begin pcw++; pcSrc = int'(PCSource); end
      if (EPCWrite) begin epcW++; exc = int'(Exception); end
      if (HIWrite) begin hi++; lastHi = cyc; end
      if (LOWrite) lo++;
      @(negedge clk);
      cyc++;
    end while (ctrl_state != 6'd0 && cyc < 200);
    chk("cycles",    idx, cyc,   v.cycles);
    chk("RegWrite",  idx, regW,  v.regW);
    chk("MemWrite",  idx, memW,  v.memW);
    chk("IRWrite",   idx, irw,   1);
    chk("PCwrite",   idx, pcw,   v.pcw);
    chk("PCSource",  idx, pcSrc, v.pcSrc);
    chk("EPCWrite",  idx, epcW,  v.epcW);
    chk("HIWrite",   idx, hi,    v.hilo);
    chk("LOWrite",   idx, lo,    v.hilo);
    chk("Exception", idx, exc,   v.exc);
    chk("MemToReg",  idx, mtr,   v.mtr);
    chk("WriteSrc",  idx, wsrc,  v.wsrc);
    chk("RegDest",   idx, rdst,  v.rdst);
    if (v.hilo > 0) chk("HIWrite_last_cycle", idx, lastHi, v.cycles - 1);
  endtask

  initial begin
    int found;
    clk = 1'b0; reset = 1'b1;
    OPCODE = '0; FUNCT = '0; ALUoverflow = 1'b0; Zero = 1'b0; ByZero = 1'b0;

    //                op    fn    z  o  b  cyc rW mW pw ps eW hl ex mtr ws rd
    vecs.push_back(mk('h08, 'h00, 0, 0, 0,  6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // addi
    vecs.push_back(mk('h00, 'h20, 0, 0, 0,  6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1)); // add
    vecs.push_back(mk('h00, 'h22, 0, 0, 0,  6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1)); // sub
    vecs.push_back(mk('h00, 'h24, 0, 1, 0,  6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1)); // and, ovf ignored
    vecs.push_back(mk('h00, 'h00, 0, 0, 0,  7, 1, 0, 0, 0, 0, 0, 0, 4, 0, 1)); // sll
    vecs.push_back(mk('h00, 'h02, 0, 0, 0,  7, 1, 0, 0, 0, 0, 0, 0, 4, 0, 1)); // srl
    vecs.push_back(mk('h00, 'h03, 0, 0, 0,  7, 1, 0, 0, 0, 0, 0, 0, 4, 0, 1)); // sra
    vecs.push_back(mk('h0f, 'h00, 0, 0, 0,  5, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0)); // lui
    vecs.push_back(mk('h2b, 'h00, 0, 0, 0,  6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // sw
    vecs.push_back(mk('h23, 'h00, 0, 0, 0,  9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0)); // lw
    vecs.push_back(mk('h20, 'h00, 0, 0, 0,  9, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0)); // lb
    vecs.push_back(mk('h04, 'h00, 1, 0, 0,  5, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)); // beq taken
    vecs.push_back(mk('h04, 'h00, 0, 0, 0,  5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // beq not taken
    vecs.push_back(mk('h05, 'h00, 1, 0, 0,  5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // bne equal
    vecs.push_back(mk('h05, 'h00, 0, 0, 0,  5, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0)); // bne taken
    vecs.push_back(mk('h02, 'h00, 0, 0, 0,  5, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0)); // j
    vecs.push_back(mk('h03, 'h00, 0, 0, 0,  6, 1, 0, 1, 2, 0, 0, 0, 0, 3, 2)); // jal
    vecs.push_back(mk('h00, 'h08, 0, 0, 0,  5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)); // jr
    vecs.push_back(mk('h00, 'h13, 0, 0, 0,  5, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0)); // rte
    vecs.push_back(mk('h00, 'h18, 0, 0, 0, 36, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)); // mult
    vecs.push_back(mk('h00, 'h18, 0, 0, 1, 36, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)); // mult again, ByZero ignored
    vecs.push_back(mk('h00, 'h1a, 0, 0, 0, 36, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)); // div
    vecs.push_back(mk('h00, 'h10, 0, 0, 0,  5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1)); // mfhi
    vecs.push_back(mk('h00, 'h12, 0, 0, 0,  5, 1, 0, 0, 0, 0, 0, 0, 0, 2, 1)); // mflo
`ifdef CTRL_EXCEPTIONS_EN
    vecs.push_back(mk('h00, 'h20, 0, 1, 0, 10, 0, 0, 1, 4, 1, 0, 2, 0, 0, 0)); // add overflow
    vecs.push_back(mk('h08, 'h00, 0, 1, 0, 10, 0, 0, 1, 4, 1, 0, 2, 0, 0, 0)); // addi overflow
    vecs.push_back(mk('h00, 'h1a, 0, 0, 1,  9, 0, 0, 1, 4, 1, 0, 3, 0, 0, 0)); // div by zero
    vecs.push_back(mk('h3f, 'h00, 0, 0, 0,  9, 0, 0, 1, 4, 1, 0, 1, 0, 0, 0)); // bad opcode
    vecs.push_back(mk('h00, 'h3e, 0, 0, 0,  9, 0, 0, 1, 4, 1, 0, 1, 0, 0, 0)); // bad funct
`else
    vecs.push_back(mk('h00, 'h20, 0, 1, 0,  6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1)); // add overflow
    vecs.push_back(mk('h08, 'h00, 0, 1, 0,  6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // addi overflow
    vecs.push_back(mk('h00, 'h1a, 0, 0, 1,  5, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)); // div by zero
    vecs.push_back(mk('h3f, 'h00, 0, 0, 0,  4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // bad opcode
    vecs.push_back(mk('h00, 'h3e, 0, 0, 0,  4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // bad funct
`endif
    vecs.push_back(mk('h00, 'h13, 0, 0, 0,  5, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0)); // rte after fault

    // Reset held: every output low, state FETCH0.
    repeat (2) @(negedge clk);
    chk("reset_outputs_nonzero", -1, int'(outBus != '0), 0);
    chk("reset_state", -1, int'(ctrl_state), 0);
    reset = 1'b0;
    #1;
    chk("fetch_memread_after_reset", -1, int'(MemRead), 1);

    foreach (vecs[i]) runVec(vecs[i], i);

    // Reset during the store cycle must kill MemWrite immediately.
    OPCODE = 6'h2b; FUNCT = 6'h00; Zero = 1'b0; ALUoverflow = 1'b0; ByZero = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge clk);
      if (MemWrite) found = 1;
    end
    chk("sw_reached_memwrite", -2, found, 1);
    reset = 1'b1;
    #1;
    chk("memwrite_after_reset", -2, int'(MemWrite), 0);
    chk("state_after_reset", -2, int'(ctrl_state), 0);
    chk("outputs_after_reset_nonzero", -2, int'(outBus != '0), 0);
    @(negedge clk);
    chk("outputs_held_in_reset_nonzero", -2, int'(outBus != '0), 0);
    reset = 1'b0;
    #1;
    chk("refetch_memread", -2, int'(MemRead), 1);
    runVec(mk('h08, 'h00, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 100);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
